puf_ro_sequencer: RTL and testbench

Sequencer for the ring-oscillator PUF array. On a start request it walks a latched challenge, enables one pair of ring oscillators at a time, counts the divided-down toggles of each over a fixed window of `ICE_CLK` cycles, and compares the two counts to produce one response bit. It sits between the free-running LUT-based oscillator/divider cells and the host logic (LED/UART) that consumes the response.

---
 rtl/puf_pkg.sv | 30 +++
 rtl/puf_edge_counter.sv | 49 ++++
 rtl/puf_ro_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_puf_ro_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF sequencer and the
// host-side challenge generator.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_NEXT
  } state_e;

  // Ceiling log2, never less than 1 so it can size a select field.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Challenge layout: bit i uses ro_a at field 2i+1 and ro_b at field 2i.
  function automatic int unsigned ro_a_lsb(input int unsigned bit_i, input int unsigned sel_w);
    return (2 * bit_i + 1) * sel_w;
  endfunction

  function automatic int unsigned ro_b_lsb(input int unsigned bit_i, input int unsigned sel_w);
    return 2 * bit_i * sel_w;
  endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Synchronizes one divided oscillator output, detects rising edges and counts
// them into a saturating counter while count_en is high.
module puf_edge_counter
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [1:0]       sync_q, sync_d;
  logic             hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    sync_d = {sync_q[0], din};
    hist_d = sync_q[1];
    rise   = sync_q[1] & ~hist_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign sat   = (cnt_q == '1);

endmodule

// File: rtl/puf_ro_sequencer.sv
// Walks a latched challenge one oscillator pair at a time, measures both
// oscillators over a fixed window and records one response bit per pair.
module puf_ro_sequencer
  import puf_pkg::*;
#(
  parameter  int unsigned N_RO       = 8,
  parameter  int unsigned RESP_BITS  = 8,
  parameter  int unsigned SETTLE_CYC = 64,
  parameter  int unsigned WINDOW     = 4096,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W      = clog2(N_RO)
) (
  input  logic                         ICE_CLK,
  input  logic                         ICE_RST,
  input  logic                         start,
  input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
  input  logic [N_RO-1:0]              ro_div,
  output logic [N_RO-1:0]              ro_en,
  output logic                         busy,
  output logic                         done,
  output logic [RESP_BITS-1:0]         response,
  output logic [RESP_BITS-1:0]         tie_mask,
  output logic                         sat
);

  localparam int unsigned IDX_W  = clog2(RESP_BITS);
  localparam int unsigned TMR_W  = clog2((SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW);
  localparam int unsigned CHAL_W = RESP_BITS * 2 * SEL_W;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CHAL_W-1:0]  chal_q, chal_d;
  logic [SEL_W-1:0]   sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic               forced_q, forced_d;
  logic [N_RO-1:0]    ro_en_q, ro_en_d;
  logic [RESP_BITS-1:0] resp_q, resp_d, tie_q, tie_d;
  logic               sat_q, sat_d;
  logic               done_q, done_d;

  logic               clr, cnt_en, enter_bit;
  logic [IDX_W-1:0]   nxt_idx;
  logic [CHAL_W-1:0]  nxt_chal;
  logic [SEL_W-1:0]   pair_a, pair_b;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic               sat_a, sat_b;
  logic               div_a, div_b;

  // Selection is registered at bit entry so the counter inputs stay put.
  assign div_a = ro_div[sel_a_q];
  assign div_b = ro_div[sel_b_q];

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (ICE_CLK),
    .rst      (ICE_RST),
    .din      (div_a),
    .clear    (clr),
    .count_en (cnt_en),
    .count    (cnt_a),
    .sat      (sat_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (ICE_CLK),
    .rst      (ICE_RST),
    .din      (div_b),
    .clear    (clr),
    .count_en (cnt_en),
    .count    (cnt_b),
    .sat      (sat_b)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    chal_d    = chal_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    forced_d  = forced_q;
    ro_en_d   = ro_en_q;
    resp_d    = resp_q;
    tie_d     = tie_q;
    sat_d     = sat_q;
    done_d    = 1'b0;
    clr       = 1'b0;
    cnt_en    = 1'b0;
    enter_bit = 1'b0;
    nxt_idx   = idx_q;
    nxt_chal  = chal_q;
    pair_a    = '0;
    pair_b    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d    = challenge;
          nxt_chal  = challenge;
          nxt_idx   = '0;
          idx_d     = '0;
          sat_d     = 1'b0;
          resp_d    = '0;
          tie_d     = '0;
          enter_bit = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
          timer_d = '0;
          clr     = 1'b1;
          state_d = ST_MEASURE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        cnt_en = 1'b1;
        if (sat_a || sat_b) sat_d = 1'b1;
        if (timer_q == TMR_W'(WINDOW - 1)) begin
          timer_d = '0;
          state_d = ST_COMPARE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_COMPARE: begin
        if (!forced_q && (sat_a || sat_b)) sat_d = 1'b1;
        resp_d[idx_q] = !forced_q && (cnt_a > cnt_b);
        tie_d[idx_q]  = forced_q || (cnt_a == cnt_b);
        ro_en_d       = '0;
        state_d       = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == IDX_W'(RESP_BITS - 1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          nxt_idx   = idx_q + 1'b1;
          idx_d     = nxt_idx;
          enter_bit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int unsigned k = 0; k < RESP_BITS; k++) begin
      if (nxt_idx == IDX_W'(k)) begin
        pair_a = nxt_chal[ro_a_lsb(k, SEL_W) +: SEL_W];
        pair_b = nxt_chal[ro_b_lsb(k, SEL_W) +: SEL_W];
      end
    end

    // A pair naming the same oscillator twice skips SETTLE/MEASURE entirely.
    if (enter_bit) begin
      sel_a_d = pair_a;
      sel_b_d = pair_b;
      timer_d = '0;
      if (pair_a == pair_b) begin
        forced_d = 1'b1;
        state_d  = ST_COMPARE;
      end else begin
        forced_d        = 1'b0;
        state_d         = ST_SETTLE;
        ro_en_d         = '0;
        ro_en_d[pair_a] = 1'b1;
        ro_en_d[pair_b] = 1'b1;
      end
    end
  end

  always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
    if (ICE_RST) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      chal_q   <= '0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      forced_q <= 1'b0;
      ro_en_q  <= '0;
      resp_q   <= '0;
      tie_q    <= '0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      chal_q   <= chal_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      forced_q <= forced_d;
      ro_en_q  <= ro_en_d;
      resp_q   <= resp_d;
      tie_q    <= tie_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign response = resp_q;
  assign tie_mask = tie_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_puf_ro_sequencer.sv
// Self-checking bench for puf_ro_sequencer: vector table plus scoreboard queue,
// with hand-written reset, saturation and start/challenge-guard sequences.
module tb_puf_ro_sequencer;

  localparam int unsigned N_RO   = 8;
  localparam int unsigned RB     = 8;
  localparam int unsigned SC     = 8;
  localparam int unsigned WIN    = 256;
  localparam int unsigned CW     = RB * 2 * 3;
  localparam int unsigned BIT_CYC = SC + WIN + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] challenge;
  logic [7:0]    ro_div;
  logic [7:0]    ro_en;
  logic          busy, done, sat;
  logic [7:0]    response, tie_mask;

  logic          s_start;
  logic [CW-1:0] s_challenge;
  logic [7:0]    s_ro_div;
  logic [7:0]    s_ro_en;
  logic          s_busy, s_done, s_sat;
  logic [7:0]    s_response, s_tie_mask;

  puf_ro_sequencer #(.N_RO(N_RO), .RESP_BITS(RB), .SETTLE_CYC(SC), .WINDOW(WIN), .CNT_W(16)) u_dut (
    .ICE_CLK(clk), .ICE_RST(rst), .start(start), .challenge(challenge), .ro_div(ro_div),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response), .tie_mask(tie_mask), .sat(sat)
  );

  puf_ro_sequencer #(.N_RO(N_RO), .RESP_BITS(RB), .SETTLE_CYC(SC), .WINDOW(WIN), .CNT_W(4)) u_sat (
    .ICE_CLK(clk), .ICE_RST(rst), .start(s_start), .challenge(s_challenge), .ro_div(s_ro_div),
    .ro_en(s_ro_en), .busy(s_busy), .done(s_done), .response(s_response), .tie_mask(s_tie_mask),
    .sat(s_sat)
  );

  always #5 clk = ~clk;

  // Oscillator models: square waves with a period in clocks, 0 = static low.
  int unsigned per_m [8];
  int unsigned per_s [8];
  int unsigned ph    [8];

  always @(posedge clk) begin
    #3;
    for (int k = 0; k < 8; k++) begin
      ro_div[k]   = (per_m[k] != 0) && ((ph[k] % per_m[k]) < per_m[k] / 2);
      s_ro_div[k] = (per_s[k] != 0) && ((ph[k] % per_s[k]) < per_s[k] / 2);
      ph[k]++;
    end
  end

  typedef struct {
    logic [CW-1:0] chal;
    logic [7:0]    exp_resp;
    logic [7:0]    exp_tie;
    logic [7:0]    exp_en;
    int unsigned   exp_lat;
    logic          exp_sat;
    bit            disturb;
  } vec_t;

  vec_t vecs [7];
  vec_t sb_q [$];

  int   checks = 0;
  int   errors = 0;
  logic       mon_on = 1'b0;
  logic [7:0] en_acc;

  always @(negedge clk) if (mon_on) en_acc |= ro_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] put_pair(input logic [CW-1:0] c, input int unsigned i,
                                             input int unsigned a, input int unsigned b);
    logic [CW-1:0] r;
    r = c;
    r[(2*i+1)*3 +: 3] = 3'(a);
    r[2*i*3 +: 3]     = 3'(b);
    return r;
  endfunction

  function automatic logic [CW-1:0] uniform(input int unsigned a, input int unsigned b);
    logic [CW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < RB; i++) r = put_pair(r, i, a, b);
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    vec_t e;
    int unsigned lat;
    sb_q.push_back(v);
    challenge = v.chal;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d busy_rise", id), 32'(busy), 32'd1);
    en_acc = '0;
    mon_on = 1'b1;
    lat    = 0;
    while (!done && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
      if (v.disturb && lat == 300) begin
        start     = 1'b1;
        challenge = ~v.chal;
      end
      if (lat == 301) start = 1'b0;
    end
    mon_on = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("v%0d done_seen", id), 32'(done), 32'd1);
    check($sformatf("v%0d latency", id), lat, e.exp_lat);
    check($sformatf("v%0d busy_at_done", id), 32'(busy), 32'd0);
    check($sformatf("v%0d response", id), 32'(response), 32'(e.exp_resp));
    check($sformatf("v%0d tie_mask", id), 32'(tie_mask), 32'(e.exp_tie));
    check($sformatf("v%0d sat", id), 32'(sat), 32'(e.exp_sat));
    check($sformatf("v%0d ro_en_union", id), 32'(en_acc), 32'(e.exp_en));
    @(posedge clk); #1;
    check($sformatf("v%0d done_pulse_width", id), 32'(done), 32'd0);
  endtask

  initial begin
    logic [CW-1:0] c;
    int unsigned lat;

    rst = 1'b1; start = 1'b0; challenge = '0; s_start = 1'b0; s_challenge = '0;
    ro_div = '0; s_ro_div = '0;
    for (int k = 0; k < 8; k++) begin per_m[k] = 0; per_s[k] = 0; ph[k] = 0; end
    per_m[1] = 8; per_m[2] = 12;
    per_s[1] = 4; per_s[2] = 4;

    vecs[0] = '{uniform(1, 2), 8'hFF, 8'h00, 8'h06, 8 * BIT_CYC, 1'b0, 1'b0};
    vecs[1] = '{uniform(2, 1), 8'h00, 8'h00, 8'h06, 8 * BIT_CYC, 1'b0, 1'b0};
    vecs[2] = '{put_pair(uniform(1, 2), 5, 4, 4), 8'hDF, 8'h20, 8'h06, 8 * BIT_CYC - 264, 1'b0, 1'b0};
    c = '0;
    for (int unsigned i = 0; i < RB; i++) c = (i % 2 == 0) ? put_pair(c, i, 1, 2) : put_pair(c, i, 2, 1);
    vecs[3] = '{c, 8'h55, 8'h00, 8'h06, 8 * BIT_CYC, 1'b0, 1'b0};
    vecs[4] = '{uniform(3, 3), 8'h00, 8'hFF, 8'h00, 16, 1'b0, 1'b0};
    c = '0;
    for (int unsigned i = 0; i < RB; i++)
      c = (i < 3) ? put_pair(c, i, 1, 3) : (i < 7) ? put_pair(c, i, 3, 1) : put_pair(c, i, 5, 3);
    vecs[5] = '{c, 8'h07, 8'h80, 8'h2A, 8 * BIT_CYC, 1'b0, 1'b0};
    vecs[6] = '{uniform(1, 2), 8'hFF, 8'h00, 8'h06, 8 * BIT_CYC, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset ro_en", 32'(ro_en), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset response", 32'(response), 32'd0);
    check("reset tie_mask", 32'(tie_mask), 32'd0);
    check("reset sat", 32'(s_sat), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset during MEASURE of bit 3 discards the partial response.
    challenge = uniform(1, 2);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3 * BIT_CYC + SC + 100) @(posedge clk);
    #1;
    check("midrun partial response", 32'(response[2:0]), 32'd7);
    check("midrun ro_en pair", 32'(ro_en), 32'h06);
    rst = 1'b1;
    #1;
    check("midrun rst ro_en", 32'(ro_en), 32'd0);
    check("midrun rst busy", 32'(busy), 32'd0);
    check("midrun rst response", 32'(response), 32'd0);
    check("midrun rst tie_mask", 32'(tie_mask), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0], 10);

    // Saturating counters on the CNT_W=4 instance.
    s_challenge = uniform(1, 2);
    s_start     = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("sat done_seen", 32'(s_done), 32'd1);
    check("sat latency", lat, 8 * BIT_CYC);
    check("sat flag", 32'(s_sat), 32'd1);
    check("sat tie_mask", 32'(s_tie_mask), 32'hFF);
    check("sat response", 32'(s_response), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
